// File: rtl/leds7_cmd_arbiter.sv
// Round-robin arbiter serialising per-requester "digit D = value V" commands into the
// Leds7 select/data byte stream. Define LEDS7_ARB_DEDUP_EN to drop commands that would rewrite an unchanged digit.
module leds7_cmd_arbiter #(
    parameter int N_REQ      = 2,
    parameter int GAP_CYCLES = 0,
    parameter int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [2*N_REQ-1:0]   req_led,
    input  logic [4*N_REQ-1:0]   req_value,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic                 cmd_dropped
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_GAP_A = 3'd2,
        ST_DATA  = 3'd3,
        ST_GAP_B = 3'd4
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [1:0]       led_q, led_d;
    logic [3:0]       value_q, value_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [N_REQ-1:0] req_ready_s;
    logic             any_req_s;
    logic [IDW-1:0]   grant_idx_s;
    int               idx_s;
    logic [1:0]       sel_led_s;
    logic [3:0]       sel_value_s;
`ifdef LEDS7_ARB_DEDUP_EN
    logic [3:0]       shadow_q [4];
    logic [3:0]       shadow_d [4];
    logic             cmd_dropped_q, cmd_dropped_d;
`endif

    // Round-robin search: scanning offsets high to low lets the lowest offset from rr_ptr win.
    always_comb begin
        any_req_s   = 1'b0;
        grant_idx_s = '0;
        idx_s       = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx_s = (int'(rr_ptr_q) + i) % N_REQ;
            if (req_valid[idx_s]) begin
                any_req_s   = 1'b1;
                grant_idx_s = IDW'(idx_s);
            end else begin
                any_req_s   = any_req_s;
            end
        end
        sel_led_s   = req_led[2*int'(grant_idx_s) +: 2];
        sel_value_s = req_value[4*int'(grant_idx_s) +: 4];
    end

    // Next-state and next-output logic for the command serialiser.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        led_d       = led_q;
        value_d     = value_q;
        gap_cnt_d   = gap_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        req_ready_s = '0;
`ifdef LEDS7_ARB_DEDUP_EN
        shadow_d      = shadow_q;
        cmd_dropped_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req_s && !reset) begin
                    req_ready_s[grant_idx_s] = 1'b1;
                    grant_id_d = grant_idx_s;
                    rr_ptr_d   = IDW'((int'(grant_idx_s) + 1) % N_REQ);
                    led_d      = sel_led_s;
                    value_d    = sel_value_s;
`ifdef LEDS7_ARB_DEDUP_EN
                    if (sel_value_s == shadow_q[sel_led_s]) begin
                        cmd_dropped_d = 1'b1;
                    end else begin
                        state_d     = ST_SEL;
                        out_valid_d = 1'b1;
                        out_data_d  = {6'b111100, sel_led_s};
                    end
`else
                    state_d     = ST_SEL;
                    out_valid_d = 1'b1;
                    out_data_d  = {6'b111100, sel_led_s};
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEL: begin
                if (GAP_CYCLES == 0) begin
                    state_d     = ST_DATA;
                    out_valid_d = 1'b1;
                    out_data_d  = {4'h0, value_q};
                end else begin
                    state_d   = ST_GAP_A;
                    gap_cnt_d = GAP_LAST;
                end
            end
            ST_GAP_A: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d     = ST_DATA;
                    out_valid_d = 1'b1;
                    out_data_d  = {4'h0, value_q};
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            ST_DATA: begin
`ifdef LEDS7_ARB_DEDUP_EN
                shadow_d[led_q] = value_q;
`endif
                if (GAP_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_GAP_B;
                    gap_cnt_d = GAP_LAST;
                end
            end
            ST_GAP_B: begin
                if (gap_cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; synchronous reset takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            led_q       <= 2'd0;
            value_q     <= 4'd0;
            gap_cnt_q   <= 8'd0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef LEDS7_ARB_DEDUP_EN
            cmd_dropped_q <= 1'b0;
            for (int j = 0; j < 4; j++) begin
                shadow_q[j] <= 4'd0;
            end
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            led_q       <= led_d;
            value_q     <= value_d;
            gap_cnt_q   <= gap_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
`ifdef LEDS7_ARB_DEDUP_EN
            cmd_dropped_q <= cmd_dropped_d;
            for (int j = 0; j < 4; j++) begin
                shadow_q[j] <= shadow_d[j];
            end
`endif
        end
    end

    assign req_ready = req_ready_s;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;
`ifdef LEDS7_ARB_DEDUP_EN
    assign cmd_dropped = cmd_dropped_q;
`else
    assign cmd_dropped = 1'b0;
`endif

endmodule

// File: tb/tb_leds7_cmd_arbiter.sv
// Directed scoreboard bench: instance A (3 requesters, no gap) and instance B (2 requesters, gap of 3).
module tb_leds7_cmd_arbiter;

`ifdef LEDS7_ARB_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]  va, rra;
    logic [5:0]  leda;
    logic [11:0] vala;
    logic [7:0]  oda;
    logic        ova, busya, dropa;
    logic [1:0]  gida;

    logic [1:0]  vb, rrb;
    logic [3:0]  ledb;
    logic [7:0]  valb;
    logic [7:0]  odb;
    logic        ovb, busyb, dropb;
    logic [0:0]  gidb;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int         grant_a[$];
    logic [2:0] exp_rr_m;

    leds7_cmd_arbiter #(.N_REQ(3), .GAP_CYCLES(0)) dut_a (
        .clk(clk), .reset(reset), .req_valid(va), .req_ready(rra), .req_led(leda),
        .req_value(vala), .out_data(oda), .out_valid(ova), .busy(busya),
        .grant_id(gida), .cmd_dropped(dropa)
    );

    leds7_cmd_arbiter #(.N_REQ(2), .GAP_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .req_valid(vb), .req_ready(rrb), .req_led(ledb),
        .req_value(valb), .out_data(odb), .out_valid(ovb), .busy(busyb),
        .grant_id(gidb), .cmd_dropped(dropb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Scoreboard: every emitted byte and every grant is matched against the queued expectation.
    always @(negedge clk) begin
        if (ova === 1'b1) begin
            if (exp_a.size() == 0) chk("a_unexpected_byte_queue_size", 32'(exp_a.size()), 32'd1);
            else chk("a_byte", 32'(oda), 32'(exp_a.pop_front()));
        end
        if (ovb === 1'b1) begin
            if (exp_b.size() == 0) chk("b_unexpected_byte_queue_size", 32'(exp_b.size()), 32'd1);
            else chk("b_byte", 32'(odb), 32'(exp_b.pop_front()));
        end
        if (rra !== 3'b000) begin
            chk("a_ready_without_valid", 32'(rra & ~va), 32'd0);
            if (grant_a.size() == 0) begin
                chk("a_unexpected_grant_queue_size", 32'(grant_a.size()), 32'd1);
            end else begin
                exp_rr_m = 3'b001 << grant_a.pop_front();
                chk("a_grant", 32'(rra), 32'(exp_rr_m));
            end
        end
    end

    initial begin
        logic [2:0] fr_exp;
        int r;
        int n;
        va = 3'b000; leda = 6'd0; vala = 12'd0;
        vb = 2'b00;  ledb = 4'd0; valb = 8'd0;
        reset = 1'b1;
        repeat (3) tick();
        at_neg();
        chk("rst_a_outputs", {22'd0, oda, ova, busya, dropa}, 32'd0);
        chk("rst_a_grant_ready", {27'd0, gida, rra}, 32'd0);
        chk("rst_b_outputs", {22'd0, odb, ovb, busyb, dropb}, 32'd0);
        chk("rst_b_grant_ready", {29'd0, gidb, rrb}, 32'd0);
        tick();
        reset = 1'b0;

        // B: digit 0 := 0 straight after reset (matches reset contents).
        vb = 2'b01; ledb[1:0] = 2'd0; valb[3:0] = 4'd0;
        if (!DEDUP) begin exp_b.push_back(8'hF0); exp_b.push_back(8'h00); end
        at_neg();
        chk("b_zero_ready", 32'(rrb), 32'b01);
        tick(); vb = 2'b00;
        at_neg();
        chk("b_zero_dropped", 32'(dropb), 32'(DEDUP));
        chk("b_zero_busy", 32'(busyb), 32'(!DEDUP));
        repeat (10) tick();

        // B: gap of 3, req1 digit 0 := A.
        vb = 2'b10; ledb[3:2] = 2'd0; valb[7:4] = 4'hA;
        exp_b.push_back(8'hF0); exp_b.push_back(8'h0A);
        at_neg();
        chk("b_gap_ready", 32'(rrb), 32'b10);
        tick(); vb = 2'b00;
        at_neg();
        chk("b_gap_sel_valid", 32'(ovb), 32'd1);
        chk("b_gap_grant_id", 32'(gidb), 32'd1);
        for (int k = 2; k <= 4; k++) begin
            tick(); at_neg();
            chk("b_gap_a_quiet", 32'(ovb), 32'd0);
        end
        tick(); at_neg();
        chk("b_gap_data_valid", 32'(ovb), 32'd1);
        for (int k = 6; k <= 8; k++) begin
            tick(); at_neg();
            chk("b_gap_b_busy", {30'd0, busyb, ovb}, 32'b10);
        end
        tick(); at_neg();
        chk("b_gap_busy_clear", 32'(busyb), 32'd0);
        tick();

        // A: single command req0 digit 2 := 7.
        va = 3'b001; leda[1:0] = 2'd2; vala[3:0] = 4'd7;
        grant_a.push_back(0); exp_a.push_back(8'hF2); exp_a.push_back(8'h07);
        at_neg();
        chk("a_single_ready", 32'(rra), 32'b001);
        tick(); va = 3'b000;
        at_neg();
        chk("a_single_busy", 32'(busya), 32'd1);
        tick(); at_neg();
        tick(); at_neg();
        chk("a_single_busy_clear", 32'(busya), 32'd0);
        tick();

        // A: back-to-back from req0; second grant exactly 3 cycles later.
        va = 3'b001; leda[1:0] = 2'd1; vala[3:0] = 4'd5;
        grant_a.push_back(0); grant_a.push_back(0);
        exp_a.push_back(8'hF1); exp_a.push_back(8'h05);
        exp_a.push_back(8'hF3); exp_a.push_back(8'h09);
        at_neg();
        tick(); leda[1:0] = 2'd3; vala[3:0] = 4'd9;
        at_neg(); chk("a_b2b_ready_t1", 32'(rra), 32'd0);
        tick(); at_neg(); chk("a_b2b_ready_t2", 32'(rra), 32'd0);
        tick(); at_neg(); chk("a_b2b_ready_t3", 32'(rra), 32'b001);
        tick(); va = 3'b000;
        repeat (4) tick();

        // A: fairness with all requesters active from reset.
        reset = 1'b1; va = 3'b111; leda = 6'b10_01_00; vala = {4'd3, 4'd2, 4'd1};
        for (int k = 0; k < 6; k++) begin
            grant_a.push_back(k % 3);
            exp_a.push_back(8'hF0 | 8'(k % 3));
            exp_a.push_back(8'(3 * (k / 3) + (k % 3) + 1));
        end
        tick(); at_neg();
        chk("a_reset_ready_gated", 32'(rra), 32'd0);
        tick(); reset = 1'b0;
        for (int k = 0; k < 18; k++) begin
            at_neg();
            fr_exp = (k % 3 == 0) ? 3'(3'b001 << ((k / 3) % 3)) : 3'b000;
            chk("a_fair_ready", 32'(rra), 32'(fr_exp));
            tick();
            if (k % 3 == 0) begin
                r = (k / 3) % 3;
                n = k / 9;
                vala[4*r +: 4] = 4'(3 * (n + 1) + r + 1);
            end
            if (k == 15) va = 3'b000;
        end
        repeat (2) tick();

        // A: reset right after the select byte; no data byte follows.
        va = 3'b001; leda[1:0] = 2'd2; vala[3:0] = 4'd8;
        grant_a.push_back(0); exp_a.push_back(8'hF2);
        at_neg();
        tick(); va = 3'b000; reset = 1'b1;
        at_neg();
        chk("a_mid_sel_byte", {23'd0, ova, oda}, {23'd0, 1'b1, 8'hF2});
        tick(); reset = 1'b0;
        at_neg();
        chk("a_mid_rst_outputs", {22'd0, oda, ova, busya, dropa}, 32'd0);
        chk("a_mid_rst_grant_id", 32'(gida), 32'd0);
        tick();
        va = 3'b011; leda[3:0] = {2'd0, 2'd1}; vala[7:0] = {4'd6, 4'd3};
        grant_a.push_back(0); grant_a.push_back(1);
        exp_a.push_back(8'hF1); exp_a.push_back(8'h03);
        exp_a.push_back(8'hF0); exp_a.push_back(8'h06);
        at_neg();
        chk("a_post_rst_ready", 32'(rra), 32'b001);
        tick(); va[0] = 1'b0;
        at_neg(); tick(); at_neg(); tick(); at_neg();
        chk("a_post_rst_second_ready", 32'(rra), 32'b010);
        tick(); va = 3'b000;
        repeat (4) tick();

        // A: same digit/value written twice by req2.
        va = 3'b100; leda[5:4] = 2'd1; vala[11:8] = 4'd4;
        grant_a.push_back(2); exp_a.push_back(8'hF1); exp_a.push_back(8'h04);
        at_neg();
        tick(); va = 3'b000;
        repeat (4) tick();
        va = 3'b100;
        grant_a.push_back(2);
        if (!DEDUP) begin exp_a.push_back(8'hF1); exp_a.push_back(8'h04); end
        at_neg();
        chk("a_dup_ready", 32'(rra), 32'b100);
        tick(); va = 3'b000;
        at_neg();
        chk("a_dup_dropped", 32'(dropa), 32'(DEDUP));
        chk("a_dup_out_valid", 32'(ova), 32'(!DEDUP));
        chk("a_dup_grant_id", 32'(gida), 32'd2);
        tick(); at_neg();
        chk("a_dup_drop_pulse_end", 32'(dropa), 32'd0);
        repeat (5) tick();

        chk("a_bytes_left", 32'(exp_a.size()), 32'd0);
        chk("b_bytes_left", 32'(exp_b.size()), 32'd0);
        chk("a_grants_left", 32'(grant_a.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
